// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard/forwarding
// controller (slave): ID-stage decode info in, stage enables and operand selects out.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_memwrite;
  logic             ex_branch_taken;
  logic             dmem_ready;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             pc_sel;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             freeze;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_memwrite, ex_branch_taken, dmem_ready,
    input  fwd_a, fwd_b, pc_sel, pc_write, ifid_write, ifid_flush,
           idex_bubble, freeze, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_memwrite, ex_branch_taken, dmem_ready,
    output fwd_a, fwd_b, pc_sel, pc_write, ifid_write, ifid_flush,
           idex_bubble, freeze, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline: tracks EX/MEM/WB in a
// private scoreboard and drives forwarding selects, PC/IF/ID enables, bubbles and freeze.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);
  logic             ex_valid_reg, ex_regwrite_reg, ex_memread_reg, ex_memwrite_reg;
  logic [REG_W-1:0] ex_rd_reg;
  logic [REG_W-1:0] ex_rs_reg [2];
  logic             ex_use_reg [2];
  logic             mem_valid_reg, mem_regwrite_reg, mem_memread_reg, mem_memwrite_reg;
  logic [REG_W-1:0] mem_rd_reg;
  logic             wb_valid_reg, wb_regwrite_reg;
  logic [REG_W-1:0] wb_rd_reg;
  logic [CNT_W-1:0] stall_count_reg, stall_count_next;

  logic [REG_W-1:0] id_rs [2];
  logic             id_use [2];
  logic [1:0]       ld_match;
  logic [1:0]       fwd [2];
  logic             freeze_c, redirect_c, load_use_c;
  logic             pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;

  assign id_rs[0]  = hz.id_rs1;
  assign id_rs[1]  = hz.id_rs2;
  assign id_use[0] = hz.id_use_rs1;
  assign id_use[1] = hz.id_use_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      assign ld_match[gi] = id_use[gi] && (id_rs[gi] == ex_rd_reg);

      // MEM result is newer than WB, so it wins; x0 is hardwired and never forwards.
      always_comb begin
        fwd[gi] = 2'b00;
        if (ex_use_reg[gi] && mem_valid_reg && mem_regwrite_reg &&
            (mem_rd_reg != '0) && (mem_rd_reg == ex_rs_reg[gi]))
          fwd[gi] = 2'b10;
        else if (ex_use_reg[gi] && wb_valid_reg && wb_regwrite_reg &&
                 (wb_rd_reg != '0) && (wb_rd_reg == ex_rs_reg[gi]))
          fwd[gi] = 2'b01;
      end
    end
  endgenerate

  assign freeze_c   = mem_valid_reg && (mem_memread_reg || mem_memwrite_reg) && !hz.dmem_ready;
  assign redirect_c = ex_valid_reg && hz.ex_branch_taken;
  assign load_use_c = hz.id_valid && ex_valid_reg && ex_memread_reg &&
                      (ex_rd_reg != '0) && (|ld_match);

  always_comb begin
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    if (freeze_c) begin
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
    end else if (redirect_c) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end else if (load_use_c) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_bubble_c = 1'b1;
    end
  end

  always_comb begin
    stall_count_next = stall_count_reg;
    if (!pc_write_c && (stall_count_reg != {CNT_W{1'b1}}))
      stall_count_next = stall_count_reg + 1'b1;
  end

  // Data fields carry no reset; only the valids gate any output.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg    <= 1'b0;
      mem_valid_reg   <= 1'b0;
      wb_valid_reg    <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      stall_count_reg <= stall_count_next;
      if (!freeze_c) begin
        wb_valid_reg     <= mem_valid_reg;
        wb_regwrite_reg  <= mem_regwrite_reg;
        wb_rd_reg        <= mem_rd_reg;
        mem_valid_reg    <= ex_valid_reg;
        mem_regwrite_reg <= ex_regwrite_reg;
        mem_memread_reg  <= ex_memread_reg;
        mem_memwrite_reg <= ex_memwrite_reg;
        mem_rd_reg       <= ex_rd_reg;
        ex_valid_reg     <= hz.id_valid && !idex_bubble_c;
        ex_regwrite_reg  <= hz.id_regwrite;
        ex_memread_reg   <= hz.id_memread;
        ex_memwrite_reg  <= hz.id_memwrite;
        ex_rd_reg        <= hz.id_rd;
        ex_rs_reg[0]     <= id_rs[0];
        ex_rs_reg[1]     <= id_rs[1];
        ex_use_reg[0]    <= id_use[0];
        ex_use_reg[1]    <= id_use[1];
      end
    end
  end

  assign hz.fwd_a       = fwd[0];
  assign hz.fwd_b       = fwd[1];
  assign hz.pc_sel      = redirect_c;
  assign hz.pc_write    = pc_write_c;
  assign hz.ifid_write  = ifid_write_c;
  assign hz.ifid_flush  = ifid_flush_c;
  assign hz.idex_bubble = idex_bubble_c;
  assign hz.freeze      = freeze_c;
  assign hz.stall_count = stall_count_reg;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle expected outputs go through a
// scoreboard queue and are compared at the falling edge; a narrow-counter copy checks saturation.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_sc = 16'd0;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        ps;
    logic        pw;
    logic        iw;
    logic        fl;
    logic        bb;
    logic        fz;
    logic [15:0] sc;
  } obs_t;

  obs_t  exp_q [$];
  string tag_q [$];

  pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) m_if ();
  pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  s_if ();

  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (.clk(clk), .rst(rst), .hz(m_if));
  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(4))  sdut (.clk(clk), .rst(rst), .hz(s_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw);
    m_if.id_valid    = v;
    m_if.id_rs1      = rs1;
    m_if.id_use_rs1  = u1;
    m_if.id_rs2      = rs2;
    m_if.id_use_rs2  = u2;
    m_if.id_rd       = rd;
    m_if.id_regwrite = rw;
    m_if.id_memread  = mr;
    m_if.id_memwrite = mw;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One cycle: push expectation, compare at negedge, advance past the next rising edge.
  task automatic cyc(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                     input logic ps, input logic pw, input logic iw,
                     input logic fl, input logic bb, input logic fz);
    obs_t  e;
    obs_t  o;
    string t;
    e = {fa, fb, ps, pw, iw, fl, bb, fz, exp_sc};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    o = {m_if.fwd_a, m_if.fwd_b, m_if.pc_sel, m_if.pc_write, m_if.ifid_write,
         m_if.ifid_flush, m_if.idex_bubble, m_if.freeze, m_if.stall_count};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    $display("cycle %s: observed=%h expected=%h", t, o, e);
    chk(t, 32'(o), 32'(e));
    @(posedge clk);
    #1;
    if (!pw && exp_sc != 16'hFFFF) exp_sc++;
  endtask

  task automatic norm(input string tag, input logic [1:0] fa, input logic [1:0] fb);
    cyc(tag, fa, fb, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] s_exp;
    rst = 1'b1;
    nop();
    m_if.ex_branch_taken = 1'b0;
    m_if.dmem_ready      = 1'b1;
    s_if.id_valid = 1'b0; s_if.id_rs1 = 5'd0; s_if.id_use_rs1 = 1'b0;
    s_if.id_rs2 = 5'd0; s_if.id_use_rs2 = 1'b0; s_if.id_rd = 5'd0;
    s_if.id_regwrite = 1'b0; s_if.id_memread = 1'b0; s_if.id_memwrite = 1'b0;
    s_if.ex_branch_taken = 1'b0; s_if.dmem_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) norm("reset_idle", 2'b00, 2'b00);

    // ALU -> ALU forwarding: MEM to rs1, then WB to rs2
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); norm("add_x5", 2'b00, 2'b00);
    set_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); norm("sub_in_id", 2'b00, 2'b00);
    set_id(1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); norm("sub_ex_fwd_mem", 2'b10, 2'b00);
    nop();                                                         norm("or_ex_fwd_wb", 2'b00, 2'b01);

    // Same chain with rd=x0: never forwards
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); norm("add_x0", 2'b00, 2'b00);
    set_id(1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); norm("x0_id", 2'b00, 2'b00);
    set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); norm("x0_mem", 2'b00, 2'b00);
    nop();                                                         norm("x0_wb", 2'b00, 2'b00);

    // MEM and WB both write x10: MEM wins
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);  norm("a1_x10", 2'b00, 2'b00);
    set_id(1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0); norm("a2_x10", 2'b00, 2'b00);
    set_id(1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0); norm("sub_id", 2'b00, 2'b00);
    nop();                                                          norm("mem_beats_wb", 2'b10, 2'b10);
    for (int i = 0; i < 3; i++) norm("drain", 2'b00, 2'b00);

    // Load-use: one stall, then WB forwarding
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); norm("lw_x7", 2'b00, 2'b00);
    set_id(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    cyc("load_use_stall", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    norm("after_stall_bubble_ex", 2'b10, 2'b00);
    nop();                                                         norm("lu_fwd_wb", 2'b01, 2'b00);
    norm("drain", 2'b00, 2'b00);
    norm("drain", 2'b00, 2'b00);

    // Taken branch overrides a simultaneous load-use
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); norm("lw_x7_b", 2'b00, 2'b00);
    set_id(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    m_if.ex_branch_taken = 1'b1;
    cyc("redirect_over_lu", 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    m_if.ex_branch_taken = 1'b0;
    nop();
    norm("post_redirect", 2'b10, 2'b00);
    norm("drain", 2'b00, 2'b00);
    norm("drain", 2'b00, 2'b00);

    // Freeze for 3 cycles with a deferred redirect
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); norm("lw_frz", 2'b00, 2'b00);
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); norm("beq_id", 2'b00, 2'b00);
    set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    m_if.dmem_ready = 1'b0;
    m_if.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc("freeze", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    m_if.dmem_ready = 1'b1;
    cyc("redirect_after_freeze", 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    m_if.ex_branch_taken = 1'b0;
    nop();
    norm("post_freeze", 2'b00, 2'b00);
    norm("drain", 2'b00, 2'b00);
    norm("drain", 2'b00, 2'b00);

    // Reset in the middle of a freeze
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); norm("lw_rst", 2'b00, 2'b00);
    nop();                                                         norm("lw_ex", 2'b00, 2'b00);
    m_if.dmem_ready = 1'b0;
    cyc("freeze_pre_rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_sc = 16'd0;
    norm("after_rst", 2'b00, 2'b00);
    m_if.dmem_ready = 1'b1;

    // Counter saturation on the 4-bit copy: hold a freeze past 15 cycles
    s_if.id_valid = 1'b1; s_if.id_rd = 5'd7; s_if.id_regwrite = 1'b1; s_if.id_memread = 1'b1;
    @(posedge clk); #1;
    s_if.id_valid = 1'b0; s_if.id_regwrite = 1'b0; s_if.id_memread = 1'b0;
    @(posedge clk); #1;
    s_if.dmem_ready = 1'b0;
    s_exp = 4'd0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      $display("sat cycle %0d: stall_count=%0d expected=%0d", i, s_if.stall_count, s_exp);
      chk("sat_count", 32'(s_if.stall_count), 32'(s_exp));
      @(posedge clk); #1;
      if (s_exp != 4'hF) s_exp++;
    end
    @(negedge clk);
    chk("sat_freeze_held", 32'(s_if.freeze), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and forwarding controller for the 5-stage pipeline. It keeps its own scoreboard of the instructions in EX, MEM and WB. From that it drives the operand-forwarding selects of the two 3-input EX operand muxes, the next-PC mux select, and the pipeline-register write, bubble and flush controls. It also freezes the whole pipeline while the data memory is not ready. It sits beside the ID/EX/MEM/WB registers and is the only source of their enables.

## Interface
Parameters:
- `REG_W`, 5, register-index width
- `CNT_W`, 16, stall-counter width

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_valid`  in  1  ID stage holds a real instruction
- `id_rs1`, `id_rs2`  in  REG_W  source registers of the ID instruction
- `id_use_rs1`, `id_use_rs2`  in  1  the ID instruction actually reads rs1 / rs2
- `id_rd`  in  REG_W  destination register of the ID instruction
- `id_regwrite`  in  1  the ID instruction writes `id_rd`
- `id_memread`, `id_memwrite`  in  1  the ID instruction is a load / store
- `ex_branch_taken`  in  1  branch or jump resolved taken in EX
- `dmem_ready`  in  1  data memory completes the access this cycle
- `fwd_a`, `fwd_b`  out  2  EX operand select: 00 register file, 01 WB result, 10 MEM result
- `pc_sel`  out  1  next-PC select: 0 = PC+4, 1 = EX branch target
- `pc_write`  out  1  PC register enable
- `ifid_write`  out  1  IF/ID register enable
- `ifid_flush`  out  1  clear IF/ID to NOP
- `idex_bubble`  out  1  load NOP into ID/EX instead of the ID instruction
- `freeze`  out  1  hold ID/EX, EX/MEM and MEM/WB
- `stall_count`  out  CNT_W  saturating count of cycles with `pc_write`=0

## Operation
- Scoreboard slots EX, MEM and WB. Each slot holds: valid, rd, regwrite and memread. The EX slot also holds rs1/rs2 and use_rs1/use_rs2.
- Priority of control conditions, highest first:
  - freeze: MEM valid, MEM slot is a load or store, and `dmem_ready`=0.
  - redirect: EX valid and `ex_branch_taken`=1.
  - load-use: EX valid, EX memread, EX rd≠0, and EX rd equals `id_rs1` with `id_use_rs1`, or equals `id_rs2` with `id_use_rs2`, and `id_valid`.
  - otherwise normal.
- Freeze: `freeze`=1, `pc_write`=0, `ifid_write`=0, `ifid_flush`=0, `idex_bubble`=0. All slots hold. A pending redirect is deferred; `pc_sel` stays at the value the redirect computes, and the redirect takes effect on the first unfrozen cycle.
- Redirect: `pc_sel`=1, `pc_write`=1, `ifid_flush`=1, `idex_bubble`=1. Any load-use match in the same cycle is ignored.
- Load-use: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1, `pc_sel`=0.
- Normal: `pc_write`=1, `ifid_write`=1, all other controls 0.
- Scoreboard advance on every unfrozen edge:
  - WB←MEM and MEM←EX.
  - EX←ID fields, with valid = `id_valid` & ~`idex_bubble`.
- Forwarding for operand A; operand B is identical using rs2 and `fwd_b`:
  - `fwd_a`=10 if EX use_rs1, MEM valid, MEM regwrite, MEM rd≠0 and MEM rd = EX rs1.
  - Else `fwd_a`=01 if the same conditions hold for the WB slot.
  - Else `fwd_a`=00.
  - MEM beats WB. Register 0 never forwards.
- Forwarding selects are driven during freeze as well; they reflect the held slots.
- `stall_count` increments on each edge where `pc_write`=0 and saturates at 2^CNT_W−1. It has no wrap-around.

## Timing
- All outputs except `stall_count` are combinational from the scoreboard and current inputs, so they are valid in the same cycle.
- Reset (`rst`=1 at an edge) clears all slot valids and `stall_count`.
- Output values after reset: `fwd_a`=`fwd_b`=00, `pc_sel`=0, `pc_write`=1, `ifid_write`=1, `ifid_flush`=0, `idex_bubble`=0, `freeze`=0, `stall_count`=0.
- Reset asserted mid-freeze or mid-stall discards all in-flight slots. No pending redirect survives reset.
- Load-use costs exactly 1 stall cycle. The consumer then sees `fwd`=01 when it reaches EX, because the load is then in WB.
- A taken redirect costs 2 bubbles: the IF/ID flush and the ID/EX bubble.
- A freeze of N cycles adds N cycles to `stall_count`. A load-use stall that coincides with a freeze counts once per cycle.

## Test plan
- Reset, then idle for 5 cycles → outputs at reset values and `stall_count`=0.
- ADD x5 followed immediately by SUB using x5 as rs1, then a third instruction reading x5 as rs2 → SUB in EX gets `fwd_a`=10; the third instruction in EX gets `fwd_b`=01. Repeat with rd=x0 → selects stay 00.
- LW x7 followed by ADD reading x7 → one cycle with `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; then ADD in EX gets `fwd`=01; `stall_count`=1.
- Taken branch in EX while ID holds a dependent load-use → `pc_sel`=1, `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1; no load-use stall; `stall_count` unchanged.
- LW in MEM with `dmem_ready`=0 for 3 cycles while EX has a taken branch → `freeze`=1 and `pc_write`=0 for 3 cycles, slots hold; redirect fires on cycle 4; `stall_count`=3.
- Force the counter to 0xFFFE, then stall 3 cycles → `stall_count` ends at 0xFFFF. Assert `rst` during a freeze → reset values next cycle.
